// File: rtl/prog_ctr_seq.sv
// prog_ctr_seq: program-counter sequencer for the accumulator core.
// Advances the PC once per cycle. It holds the PC on stall and stops on halt.
// A taken branch goes through a one-bubble jump state, in which the
// registered table index addresses the jump-address ROM.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | waiting for start; PC parked at START
//   S_RUN  | fetching; PC advances unless stalled, halted or branching
//   S_JUMP | bubble; ROM sees jump_idx_o, target loaded on leaving
//   S_DONE | program halted; PC points at the halt instruction
module prog_ctr_seq #(
  parameter int unsigned A     = 4,
  parameter int unsigned W     = 10,
  parameter int unsigned START = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         stall_i,
  input  logic         halt_i,
  input  logic         branch_taken_i,
  input  logic [A-1:0] branch_idx_i,
  input  logic [W-1:0] jump_addr_i,
  output logic [A-1:0] jump_idx_o,
  output logic [W-1:0] prog_ctr_o,
  output logic         inst_valid_o,
  output logic         running_o,
  output logic         done_o,
  output logic [15:0]  cycle_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_JUMP = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [W-1:0] START_PC = START[W-1:0];

  state_e       state_q, state_d;
  logic [W-1:0] pc_q, pc_d;
  logic [A-1:0] jidx_q, jidx_d;
  logic [15:0]  cnt_q, cnt_d;
  logic         active;

  assign active = (state_q == S_RUN) || (state_q == S_JUMP);

  // State, PC, jump index and cycle counter registers; async reset to IDLE values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      pc_q    <= START_PC;
      jidx_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      jidx_q  <= jidx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, PC and counter update; every register holds by default.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    jidx_d  = jidx_q;
    cnt_d   = cnt_q;

    // The counter runs even while stalled and sticks at all-ones.
    if (active && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_RUN;
          pc_d    = START_PC;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (stall_i) begin
          state_d = S_RUN;
        end else if (halt_i) begin
          // Halt outranks a same-cycle branch, so the index stays untouched.
          state_d = S_DONE;
        end else if (branch_taken_i) begin
          jidx_d  = branch_idx_i;
          state_d = S_JUMP;
        end else begin
          pc_d = pc_q + {{(W-1){1'b0}}, 1'b1};
        end
      end
      S_JUMP: begin
        if (!stall_i) begin
          pc_d    = jump_addr_i;
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign jump_idx_o   = jidx_q;
  assign prog_ctr_o   = pc_q;
  assign cycle_cnt_o  = cnt_q;
  assign running_o    = active;
  assign done_o       = (state_q == S_DONE);
  // Only combinational input-to-output path: a stall masks the valid strobe.
  assign inst_valid_o = (state_q == S_RUN) && !stall_i;

endmodule

// File: tb/tb_prog_ctr_seq.sv
// Bench for prog_ctr_seq: directed steps followed by random traffic, all
// compared against a behavioural model of the sequencer.
module tb_prog_ctr_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stall, halt, br;
  logic [3:0]  bidx;
  logic [9:0]  jaddr;
  logic [3:0]  jidx;
  logic [9:0]  pc;
  logic        ivalid, running, done;
  logic [15:0] ccnt;

  logic [9:0]  rom [16];

  int errors = 0;
  int checks = 0;

  // Behavioural model: "active" covers RUN and JUMP, and "in_jump" marks the bubble.
  bit          m_active, m_jump, m_done;
  int unsigned m_pc, m_cnt;
  logic [3:0]  m_jidx;

  always #5 clk = ~clk;

  assign jaddr = rom[jidx];

  prog_ctr_seq #(.A(4), .W(10), .START(0)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .stall_i        (stall),
    .halt_i         (halt),
    .branch_taken_i (br),
    .branch_idx_i   (bidx),
    .jump_addr_i    (jaddr),
    .jump_idx_o     (jidx),
    .prog_ctr_o     (pc),
    .inst_valid_o   (ivalid),
    .running_o      (running),
    .done_o         (done),
    .cycle_cnt_o    (ccnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_jump = 0; m_done = 0;
    m_pc = 0; m_cnt = 0; m_jidx = 4'h0;
  endtask

  task automatic check_all();
    chk("prog_ctr",   32'(pc),      32'(m_pc));
    chk("jump_idx",   32'(jidx),    32'(m_jidx));
    chk("running",    32'(running), 32'(m_active));
    chk("done",       32'(done),    32'(m_done));
    chk("inst_valid", 32'(ivalid),  32'(m_active && !m_jump && !stall));
    chk("cycle_cnt",  32'(ccnt),    32'(m_cnt));
  endtask

  task automatic model_step(input bit st, sl, h, b, input logic [3:0] bi);
    if (!m_active) begin
      if (st) begin
        m_active = 1; m_done = 0; m_pc = 0; m_cnt = 0;
      end
    end else begin
      if (m_cnt < 65535) m_cnt++;
      if (!sl) begin
        if (m_jump) begin
          m_pc = rom[m_jidx];
          m_jump = 0;
        end else if (h) begin
          m_active = 0; m_done = 1;
        end else if (b) begin
          m_jidx = bi; m_jump = 1;
        end else begin
          m_pc = (m_pc + 1) % 1024;
        end
      end
    end
  endtask

  // One clock cycle. It is entered at posedge+1 and returns at the next posedge+1.
  task automatic cyc(input bit st, sl, h, b, input logic [3:0] bi, input bit do_chk);
    start = st; stall = sl; halt = h; br = b; bidx = bi;
    #2;
    if (do_chk) check_all();
    model_step(st, sl, h, b, bi);
    @(posedge clk); #1;
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 4'h0, 1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 10'($urandom);
    rom[2] = 10'h07A;
    rom[3] = 10'h155;
    rom[5] = 10'h3FD;
    rst = 1; start = 0; stall = 0; halt = 0; br = 0; bidx = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 0;

    // Idle cycles, then Start and sequential fetch.
    idle_cyc(2);
    cyc(1, 0, 0, 0, 4'h0, 1);
    idle_cyc(3);
    chk("pc_before_branch", 32'(pc), 32'h3);
    // Taken branch at PC=3 into ROM entry 2.
    cyc(0, 0, 0, 1, 4'h2, 1);
    chk("jump_bubble_valid", 32'(ivalid), 32'h0);
    cyc(0, 0, 0, 0, 4'h0, 1);
    chk("branch_target", 32'(pc), 32'h07A);
    cyc(1, 0, 0, 0, 4'h0, 1);
    chk("start_ignored_in_run", 32'(pc), 32'h07B);

    // Halt, restart, then stall at PC=5 including one stall in JUMP.
    cyc(0, 0, 1, 0, 4'h0, 1);
    chk("done_after_halt", 32'(done), 32'h1);
    idle_cyc(1);
    cyc(1, 0, 0, 0, 4'h0, 1);
    idle_cyc(5);
    cyc(0, 1, 0, 0, 4'h0, 1);
    cyc(0, 1, 0, 0, 4'h0, 1);
    cyc(0, 0, 0, 1, 4'h3, 1);
    cyc(0, 1, 0, 0, 4'h0, 1);
    chk("stalled_jump_pc", 32'(pc), 32'h5);
    cyc(0, 0, 0, 0, 4'h0, 1);
    chk("stalled_target", 32'(pc), 32'h155);

    // Halt and branch together at PC=9: halt wins and the index keeps 3.
    cyc(0, 0, 1, 0, 4'h0, 1);
    cyc(1, 0, 0, 0, 4'h0, 1);
    idle_cyc(9);
    cyc(0, 0, 1, 1, 4'hF, 1);
    chk("halt_pc", 32'(pc), 32'h9);
    chk("halt_keeps_idx", 32'(jidx), 32'h3);
    cyc(1, 0, 0, 0, 4'h0, 1);
    chk("restart_pc", 32'(pc), 32'h0);
    chk("restart_cnt", 32'(ccnt), 32'h0);

    // PC wrap: jump to 0x3FD, then step past 0x3FF.
    cyc(0, 0, 0, 1, 4'h5, 1);
    idle_cyc(4);
    chk("pc_wrap", 32'(pc), 32'h0);

    // Async reset in the middle of a JUMP cycle.
    cyc(0, 0, 0, 1, 4'h2, 1);
    start = 0; stall = 0; halt = 0; br = 0;
    #3;
    rst = 1;
    #1;
    model_reset();
    check_all();
    #2;
    rst = 0;
    @(posedge clk); #1;
    idle_cyc(1);

    // Random traffic.
    cyc(1, 0, 0, 0, 4'h0, 1);
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 24) == 0), ($urandom_range(0, 5) == 0),
          4'($urandom), 1);
    end

    // Cycle-counter saturation with a long stall.
    cyc(0, 0, 1, 0, 4'h0, 1);
    cyc(1, 0, 0, 0, 4'h0, 1);
    for (int i = 0; i < 65540; i++) cyc(0, 1, 0, 0, 4'h0, 0);
    cyc(0, 1, 0, 0, 4'h0, 1);
    chk("cnt_saturated", 32'(ccnt), 32'hFFFF);
    cyc(0, 0, 0, 0, 4'h0, 1);
    chk("cnt_stays_max", 32'(ccnt), 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
